cook_timer: RTL
===============

# cook_timer

Countdown timer that owns the cooking time in mm:ss. It accepts a preset from the keypad/entry logic and counts down once per second while running. It pauses on request or when the door opens, and raises a beep window when time expires. Its `minutes`/`seconds` outputs feed the digit separator, and from there the seven-segment display path.

## Interface
- `CLK_HZ`, default 100000000: clock cycles per one-second tick. Use a small value (e.g. 4) in simulation.
- `BEEP_S`, default 3: length of the beep window in seconds after expiry.

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `set_min`  in  6  preset minutes, sampled on `load`
- `set_sec`  in  6  preset seconds, sampled on `load`
- `load`  in  1  one-cycle strobe: take preset
- `start`  in  1  one-cycle strobe: begin/resume countdown
- `pause`  in  1  one-cycle strobe: suspend countdown
- `clear`  in  1  one-cycle strobe: abort, zero the time
- `door_open`  in  1  level, high while door is open
- `minutes`  out  6  current minutes, 0..59
- `seconds`  out  6  current seconds, 0..59
- `running`  out  1  high in RUN (magnetron/turntable enable)
- `beep`  out  1  high during the expiry beep window
- `done`  out  1  one-cycle pulse on reaching 00:00 from RUN

## Operation
- States: IDLE (time 00:00), SET (nonzero time, not yet started), RUN, PAUSE, DONE.
- Reset (asynchronous, `rst_n`=0): state IDLE, `minutes`=0, `seconds`=0, prescaler=0, beep counter=0, `running`=0, `beep`=0, `done`=0.
- Command priority when several are high in one cycle: `clear` > `door_open` > `pause` > `start` > `load`. Lower-priority strobes in that cycle are dropped.
- `clear`, from any state: go to IDLE, time 00:00, prescaler and beep counter 0.
- `load`, accepted only in IDLE, SET and DONE; ignored in RUN and PAUSE:
  - Each field is clamped to 59 (values 60..63 become 59).
  - If the clamped result is 00:00 the state is IDLE, otherwise SET.
  - `load` in DONE ends the beep window.
- `start`, accepted in SET and PAUSE only when `door_open`=0: go to RUN and clear the prescaler. A `start` while `door_open`=1 is ignored, not queued.
- Leaving RUN: `pause`=1 or `door_open`=1 moves RUN to PAUSE. Time and prescaler are held; the prescaler is cleared on the next `start`.
- `door_open` in DONE: go to IDLE and end the beep.
- Prescaler:
  - Counts 0..CLK_HZ-1 only in RUN.
  - A tick fires in the RUN cycle where the prescaler equals CLK_HZ-1, and the prescaler wraps to 0.
  - Width is clog2(CLK_HZ), minimum 1.
- Decrement on a tick:
  - If `seconds`>0, `seconds`-1.
  - Otherwise `minutes`-1 and `seconds`=59.
  - 00:00 is never decremented, because RUN is never entered with time 00:00.
- Expiry: a tick that produces 00:00 moves the state to DONE and asserts `done` for exactly that one cycle.
  - This takes precedence over a coincident `pause`/`door_open`; only `clear` overrides it.
  - A tick coincident with `pause`/`door_open` that does not reach 00:00 still applies the decrement, then goes to PAUSE.
- DONE:
  - Time stays at 00:00 and `beep`=1.
  - The beep counter uses the same prescaler and counts BEEP_S ticks, then the state goes to IDLE with `beep`=0.
  - If BEEP_S=0, DONE lasts one cycle and `beep` never asserts.
- Output decode: `running`=1 only in RUN; `beep`=1 only in DONE.

## Timing
- All outputs are registered; none are combinational from inputs.
- A strobe sampled at edge N takes effect on the outputs after edge N.
- `start` sampled at edge N: `running`=1 after N. The first decrement is visible after edge N+CLK_HZ, and each later decrement follows CLK_HZ cycles after the previous one.
- A preset of M:S therefore expires exactly (60·M+S)·CLK_HZ cycles after the `start` edge, excluding paused time.
- `done` is high the cycle after the tick edge that produced 00:00, together with `beep`=1 and `running`=0.
- The beep window lasts BEEP_S·CLK_HZ cycles, then `beep` goes to 0 and the state goes to IDLE.
- Pause/resume: elapsed prescaler progress is discarded on resume. The remaining time on the display is exact, but the sub-second phase restarts.
- Reset asserted mid-RUN or mid-DONE: outputs reach their reset values asynchronously, without waiting for `clk`.

## Test plan
All scenarios use CLK_HZ=4 and BEEP_S=2.
- Load 0:03, start: `seconds` reads 2, 1, 0 at 4, 8, 12 cycles after start. `done` pulses once at cycle 12, `beep` is high for 8 cycles, then IDLE with 00:00.
- Load 1:00, start, run 1 tick: time reads 0:59. Load 63:63 from IDLE: time reads 59:59 and the state is SET.
- Load 0:05, start, 2 ticks, pause, wait 20 cycles: time stays 0:03 and `running`=0. Restart: the next decrement comes 4 cycles later.
- `door_open`=1 in RUN: PAUSE at 0:0x with `running`=0. `start` while the door is open is ignored. Close the door and `start`: RUN resumes.
- At 0:01, assert `pause` in the same cycle as the final tick: DONE, `done` pulses, time 00:00. Separately, `clear` and `start` together in SET: IDLE, 00:00, `running`=0.
- Assert `rst_n`=0 asynchronously mid-RUN at 2:30: all outputs are 0 immediately. `load` of 0:00 gives IDLE, and a following `start` is ignored.

Source files
------------

// File: rtl/cook_timer.sv
// cook_timer: mm:ss countdown with preset load, pause/resume, door interlock
// and a post-expiry beep window. All outputs are registered.
`default_nettype none

module cook_timer #(
    parameter int CLK_HZ = 100000000,
    parameter int BEEP_S = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       door_open,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       beep,
    output logic       done
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BEEP_S > 1) ? $clog2(BEEP_S) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'((BEEP_S > 0) ? BEEP_S - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [BW-1:0] beep_cnt;

    logic       tick;
    logic       hold;
    logic       cmd_ok;
    logic [5:0] dec_min;
    logic [5:0] dec_sec;
    logic       dec_zero;
    logic [5:0] ld_min;
    logic [5:0] ld_sec;
    logic       ld_zero;

    always_comb begin
        tick    = (presc == PRESC_MAX);
        hold    = door_open | pause;
        // start is only honoured when neither door nor pause outranks it
        cmd_ok  = !door_open && !pause;
        dec_min = minutes;
        dec_sec = seconds - 6'd1;
        if (seconds == 6'd0) begin
            dec_min = minutes - 6'd1;
            dec_sec = 6'd59;
        end
        dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0);
        ld_min   = (set_min > 6'd59) ? 6'd59 : set_min;
        ld_sec   = (set_sec > 6'd59) ? 6'd59 : set_sec;
        ld_zero  = (ld_min == 6'd0) && (ld_sec == 6'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            minutes  <= 6'd0;
            seconds  <= 6'd0;
            presc    <= '0;
            beep_cnt <= '0;
            running  <= 1'b0;
            beep     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state    <= S_IDLE;
                minutes  <= 6'd0;
                seconds  <= 6'd0;
                presc    <= '0;
                beep_cnt <= '0;
                running  <= 1'b0;
                beep     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_SET: begin
                        if (cmd_ok && start) begin
                            if (state == S_SET) begin
                                state   <= S_RUN;
                                presc   <= '0;
                                running <= 1'b1;
                            end
                        end else if (cmd_ok && load) begin
                            minutes <= ld_min;
                            seconds <= ld_sec;
                            state   <= ld_zero ? S_IDLE : S_SET;
                        end
                    end
                    S_RUN: begin
                        if (tick) begin
                            presc   <= '0;
                            minutes <= dec_min;
                            seconds <= dec_sec;
                            // expiry wins over a coincident pause or door event
                            if (dec_zero) begin
                                state    <= S_DONE;
                                running  <= 1'b0;
                                done     <= 1'b1;
                                beep     <= (BEEP_S != 0);
                                beep_cnt <= '0;
                            end else if (hold) begin
                                state   <= S_PAUSE;
                                running <= 1'b0;
                            end
                        end else if (hold) begin
                            state   <= S_PAUSE;
                            running <= 1'b0;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (cmd_ok && start) begin
                            state   <= S_RUN;
                            presc   <= '0;
                            running <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (door_open) begin
                            state    <= S_IDLE;
                            beep     <= 1'b0;
                            presc    <= '0;
                            beep_cnt <= '0;
                        end else if (cmd_ok && !start && load) begin
                            minutes  <= ld_min;
                            seconds  <= ld_sec;
                            state    <= ld_zero ? S_IDLE : S_SET;
                            beep     <= 1'b0;
                            presc    <= '0;
                            beep_cnt <= '0;
                        end else if (BEEP_S == 0) begin
                            state <= S_IDLE;
                        end else if (tick) begin
                            presc <= '0;
                            if (beep_cnt == BEEP_LAST) begin
                                state    <= S_IDLE;
                                beep     <= 1'b0;
                                beep_cnt <= '0;
                            end else begin
                                beep_cnt <= beep_cnt + 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        running <= 1'b0;
                        beep    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
